alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//  Parametrised sequential ALU for the RISC datapath. Single-cycle ADD/SUB/AND/OR; iterative MUL (shift-add) and DIV (restoring).
//  Sits between register-file read and writeback. Uses a valid/ready handshake so the control FSM stalls on MUL/DIV.
//  Adds status flags and divide-by-zero detection.
// PARAMETERS
//  WIDTH   16   operand/result width in bits (>=4)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand/opcode present
//  in_ready   out  1      block can accept (high only in IDLE)
//  op         in   3      000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 DIV, 11x reserved
//  a, b       in   WIDTH  operands, unsigned
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  ADD/SUB/AND/OR low bits; MUL low half of product; DIV quotient
//  flag_z     out  1      result == 0
//  flag_c     out  1      ADD: carry out; SUB: no-borrow (a>=b); else 0
//  flag_v     out  1      ADD/SUB signed overflow; MUL: product high half != 0; else 0
//  flag_dz    out  1      DIV with b == 0
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1; out_valid=0; result and all flags=0. Reset mid-MUL/DIV aborts; the operation is lost.
//  - Accept on in_valid && in_ready. Operands and op are latched; later input changes are ignored.
//  - FSM: IDLE --accept fast op/reserved/DIV-by-0--> DONE; IDLE --accept MUL/DIV--> BUSY;
//    BUSY --count==WIDTH-1--> DONE; DONE --out_ready--> IDLE.
//  - Latency, measured from the accept edge: fast ops out_valid at +1 cycle; MUL/DIV at +WIDTH+1; DIV by 0 at +1.
//  - DONE holds result and flags stable until out_ready. There is no accept in DONE, so peak throughput is 1 op per 2 cycles.
//  - SUB = a + ~b + 1 in WIDTH+1 bits. Arithmetic wraps modulo 2^WIDTH.
//  - MUL: 2*WIDTH-bit accumulator, one bit per cycle, LSB first.
//  - DIV: restoring, one quotient bit per cycle, MSB first.
//  - DIV by 0: quotient all ones, remainder = a, flag_dz=1, other flags follow result.
//  - Reserved op: result 0, flag_z=1, other flags 0.
//  - in_valid while not in IDLE: ignored. The producer must hold its request until in_ready.
//  - out_ready while out_valid=0: no effect.
// CONFIGURATION
//  ALU_HI_OUT_EN defined: adds output port result_hi [WIDTH], reset 0.
//    MUL gives the product high half; DIV gives the remainder; all other ops give 0.
//  ALU_HI_OUT_EN undefined: port absent. The product high half and remainder stay internal.
//    Timing and the other outputs are identical in both builds.
// STRUCTURE
//  alu_pkg: opcode localparams (OP_ADD..OP_DIV) and FSM state encodings (S_IDLE, S_BUSY, S_DONE).
//  Sub-module alu_iter_muldiv: iterative MUL/DIV datapath with a start/done pulse interface.
//    It owns the accumulator, the shift registers and the cycle counter.
//  Top-level: FSM, handshake, fast-op datapath, flag generation and output registers.
// TESTING
//  1. Reset: hold rst 3 cycles with in_valid=1 -> in_ready=1, out_valid=0, result=0, all flags 0.
//  2. ADD 16'hFFFF+16'h0001 -> out_valid 1 cycle later, result 0, flag_z=1, flag_c=1, flag_v=0.
//     SUB 16'h8000-16'h0001 -> result 16'h7FFF, flag_v=1, flag_c=1.
//  3. MUL 16'h0100*16'h0100 -> out_valid at +17, result 0, flag_v=1, result_hi=16'h0001 (macro on).
//     MUL 300*200 -> result 16'hEA60.
//  4. DIV 1000/7 -> out_valid at +17, result 142, result_hi=6.
//     DIV 5/0 -> out_valid at +1, result 16'hFFFF, flag_dz=1, result_hi=5.
//  5. Backpressure: out_ready=0 for 10 cycles after done -> result stable, in_ready=0, new in_valid ignored.
//     Then out_ready=1 -> IDLE on the next cycle.
//  6. Abort: assert rst at cycle 8 of a DIV -> outputs cleared.
//     A following ADD 2+3 -> result 5 at +1. Rerun 2-4 with WIDTH=8 and WIDTH=32.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the multicycle ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative datapath: shift-add multiply (LSB first) and restoring divide (MSB first).
// One step per cycle after start; done is high during the final step and lo/hi carry that step's result.
module alu_iter_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               busy;
  logic               div_mode;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvsr;

  logic [2*WIDTH-1:0] prod_nx;
  logic [WIDTH:0]     rem_sh;
  logic               fits;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;

  // Next step of both algorithms; the remainder after a fit is always below the divisor.
  always_comb begin
    prod_nx = mplier[0] ? (prod + mcand) : prod;
    rem_sh  = {rem, quo[WIDTH-1]};
    fits    = (rem_sh >= {1'b0, dvsr});
    if (fits) begin
      rem_nx = rem_sh[WIDTH-1:0] - dvsr;
    end else begin
      rem_nx = rem_sh[WIDTH-1:0];
    end
    quo_nx = {quo[WIDTH-2:0], fits};
    done   = busy && (count == LAST);
    lo     = div_mode ? quo_nx : prod_nx[WIDTH-1:0];
    hi     = div_mode ? rem_nx : prod_nx[2*WIDTH-1:WIDTH];
  end

  // Operand load on start, then one iteration per cycle until the last count.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      div_mode <= 1'b0;
      count    <= {CW{1'b0}};
      prod     <= {(2*WIDTH){1'b0}};
      mcand    <= {(2*WIDTH){1'b0}};
      mplier   <= {WIDTH{1'b0}};
      rem      <= {WIDTH{1'b0}};
      quo      <= {WIDTH{1'b0}};
      dvsr     <= {WIDTH{1'b0}};
    end else if (start) begin
      busy     <= 1'b1;
      div_mode <= is_div;
      count    <= {CW{1'b0}};
      prod     <= {(2*WIDTH){1'b0}};
      mcand    <= {{WIDTH{1'b0}}, a};
      mplier   <= b;
      rem      <= {WIDTH{1'b0}};
      quo      <= a;
      dvsr     <= b;
    end else if (busy) begin
      prod   <= prod_nx;
      mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      rem    <= rem_nx;
      quo    <= quo_nx;
      count  <= count + {{(CW-1){1'b0}}, 1'b1};
      busy   <= ~done;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Sequential ALU with valid/ready handshake: fast ADD/SUB/AND/OR, iterative MUL/DIV, status flags.
// Optional macro ALU_HI_OUT_EN adds result_hi (MUL high half / DIV remainder).
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_dz
`ifdef ALU_HI_OUT_EN
  ,
  output logic [WIDTH-1:0] result_hi
`endif
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  state_t           state;
  logic [2:0]       op_r;
  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             load_out;
  logic [WIDTH-1:0] cap_result;
  logic             cap_z;
  logic             cap_c;
  logic             cap_v;
  logic             cap_dz;

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .is_div (op == OP_DIV),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  // Fast-op datapath and selection of the values captured into the output registers.
  always_comb begin
    sum        = {1'b0, a} + {1'b0, b};
    diff       = {1'b0, a} + {1'b0, ~b} + {ZERO, 1'b1};
    accept     = in_valid && in_ready;
    md_start   = accept && ((op == OP_MUL) || ((op == OP_DIV) && (b != ZERO)));
    load_out   = 1'b0;
    cap_result = ZERO;
    cap_c      = 1'b0;
    cap_v      = 1'b0;
    cap_dz     = 1'b0;
    if (state == S_BUSY) begin
      load_out   = md_done;
      cap_result = md_lo;
      cap_v      = (op_r == OP_MUL) && (md_hi != ZERO);
    end else if (accept && !md_start) begin
      load_out = 1'b1;
      case (op)
        OP_ADD: begin
          cap_result = sum[WIDTH-1:0];
          cap_c      = sum[WIDTH];
          cap_v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SUB: begin
          cap_result = diff[WIDTH-1:0];
          cap_c      = diff[WIDTH];
          cap_v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        end
        OP_AND: cap_result = a & b;
        OP_OR:  cap_result = a | b;
        OP_DIV: begin
          cap_result = ONES;
          cap_dz     = 1'b1;
        end
        default: cap_result = ZERO;
      endcase
    end else begin
      load_out = 1'b0;
    end
    cap_z = (cap_result == ZERO);
  end

  // Control FSM, handshake and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_r      <= OP_ADD;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= ZERO;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      flag_dz   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_r     <= op;
            in_ready <= 1'b0;
            state    <= md_start ? S_BUSY : S_DONE;
          end
        end
        S_BUSY: begin
          if (md_done) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
      if (load_out) begin
        out_valid <= 1'b1;
        result    <= cap_result;
        flag_z    <= cap_z;
        flag_c    <= cap_c;
        flag_v    <= cap_v;
        flag_dz   <= cap_dz;
      end
    end
  end

`ifdef ALU_HI_OUT_EN
  // High-half output: product high half, remainder, or the dividend on divide-by-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_hi <= ZERO;
    end else if (load_out) begin
      if (state == S_BUSY) begin
        result_hi <= md_hi;
      end else if (op == OP_DIV) begin
        result_hi <= a;
      end else begin
        result_hi <= ZERO;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed vector table, multi-cycle corner sequences,
// and random operations against an arithmetic reference model.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic         z, c, v, dz;
    logic [W-1:0] hi;
    int           lat;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b;
    exp_t         e;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_z, flag_c, flag_v, flag_dz;
`ifdef ALU_HI_OUT_EN
  logic [W-1:0] result_hi;
`endif

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_dz   (flag_dz)
`ifdef ALU_HI_OUT_EN
    ,
    .result_hi (result_hi)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, req);
    end
  endtask

  // Reference model computed from the arithmetic definition of each operation.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint m  = longint'(1) << W;
    longint ua = longint'(x);
    longint ub = longint'(y);
    longint sa = (ua >= m / 2) ? ua - m : ua;
    longint sb = (ub >= m / 2) ? ub - m : ub;
    longint r;
    longint s;
    e.res = '0; e.z = 1'b0; e.c = 1'b0; e.v = 1'b0; e.dz = 1'b0; e.hi = '0; e.lat = 1;
    case (o)
      OP_ADD: begin
        r = ua + ub; s = sa + sb;
        e.res = W'(r % m); e.c = (r >= m); e.v = (s >= m / 2) || (s < -m / 2);
      end
      OP_SUB: begin
        r = ua - ub; s = sa - sb;
        e.res = W'((r + m) % m); e.c = (ua >= ub); e.v = (s >= m / 2) || (s < -m / 2);
      end
      OP_AND: e.res = x & y;
      OP_OR:  e.res = x | y;
      OP_MUL: begin
        r = ua * ub;
        e.res = W'(r % m); e.hi = W'(r / m); e.v = (r / m) != 0; e.lat = W + 1;
      end
      OP_DIV: begin
        if (ub == 0) begin
          e.res = W'(m - 1); e.hi = x; e.dz = 1'b1;
        end else begin
          e.res = W'(ua / ub); e.hi = W'(ua % ub); e.lat = W + 1;
        end
      end
      default: e.res = '0;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  function automatic vec_t mk(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic [W-1:0] res, input logic z, input logic c, input logic v,
                              input logic dz, input logic [W-1:0] hi, input int lat);
    vec_t t;
    t.op = o; t.a = x; t.b = y;
    t.e.res = res; t.e.z = z; t.e.c = c; t.e.v = v; t.e.dz = dz; t.e.hi = hi; t.e.lat = lat;
    return t;
  endfunction

  task automatic check_outputs(input string nm, input exp_t e);
    check({nm, ".result"}, result, e.res);
    check({nm, ".z"}, flag_z, e.z);
    check({nm, ".c"}, flag_c, e.c);
    check({nm, ".v"}, flag_v, e.v);
    check({nm, ".dz"}, flag_dz, e.dz);
`ifdef ALU_HI_OUT_EN
    check({nm, ".hi"}, result_hi, e.hi);
`endif
  endtask

  // Issue one op, measure latency from the accept edge, optionally stall the consumer.
  task automatic run_op(input string nm, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input exp_t e, input int stall);
    int n = 0;
    int g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    check({nm, ".ready_wait"}, in_ready, 1'b1);
    out_ready = (stall == 0);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    n = 1;
    while (!out_valid && n < 3 * W) begin
      @(posedge clk); #1; n++;
    end
    check({nm, ".out_valid"}, out_valid, 1'b1);
    check({nm, ".latency"}, 64'(n), 64'(e.lat));
    check_outputs(nm, e);
    if (stall > 0) begin
      in_valid = 1'b1; op = OP_ADD; a = W'(1); b = W'(1);
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check({nm, ".hold_result"}, result, e.res);
        check({nm, ".hold_valid"}, out_valid, 1'b1);
        check({nm, ".hold_in_ready"}, in_ready, 1'b0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({nm, ".drained"}, out_valid, 1'b0);
    check({nm, ".idle_ready"}, in_ready, 1'b1);
  endtask

  vec_t tbl[15];

  initial begin
    exp_t e;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;

    tbl[0]  = mk(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1);
    tbl[1]  = mk(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1);
    tbl[2]  = mk(OP_MUL, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 17);
    tbl[3]  = mk(OP_MUL, 16'd300,  16'd200,  16'hEA60, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 17);
    tbl[4]  = mk(OP_DIV, 16'd1000, 16'd7,    16'd142,  1'b0, 1'b0, 1'b0, 1'b0, 16'd6,    17);
    tbl[5]  = mk(OP_DIV, 16'd5,    16'd0,    16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5,    1);
    tbl[6]  = mk(OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1);
    tbl[7]  = mk(OP_OR,  16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1);
    tbl[8]  = mk(3'b110, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1);
    tbl[9]  = mk(OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1);
    tbl[10] = mk(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1);
    tbl[11] = mk(OP_DIV, 16'd0,    16'd3,    16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 17);
    tbl[12] = mk(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFE, 17);
    tbl[13] = mk(3'b111, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1);
    tbl[14] = mk(OP_DIV, 16'd7,    16'd1000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd7,    17);

    // Reset with a pending request.
    rst = 1'b1; in_valid = 1'b1; op = OP_ADD; a = W'(1); b = W'(1); out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", in_ready, 1'b1);
    check("reset.out_valid", out_valid, 1'b0);
    e = mk(3'b000, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1).e;
    check_outputs("reset", e);
    in_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e, 0);
    end

    run_op("backpressure", OP_MUL, 16'd300, 16'd200, tbl[3].e, 10);

    // Abort a divide part-way through with reset.
    in_valid = 1'b1; op = OP_DIV; a = 16'd1000; b = 16'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("abort.busy_valid", out_valid, 1'b0);
    check("abort.busy_ready", in_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.out_valid", out_valid, 1'b0);
    check("abort.in_ready", in_ready, 1'b1);
    check_outputs("abort", e);
    run_op("post_abort_add", OP_ADD, 16'd2, 16'd3, model(OP_ADD, 16'd2, 16'd3), 0);

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 5) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      rb = ($urandom_range(0, 6) == 0) ? W'(0) : W'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        rb = W'($urandom_range(1, 15));
      end
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, model(ro, ra, rb),
             int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
